// File: rtl/uart_ev_pkg.sv
// Shared types and constants for the UART event path.
// Contents:
//   TS_W / ID_W   default timestamp and event-id widths
//   ev_t          packed event record {id, start_ts, end_ts, delta}
//   LINE_BYTES    bytes per formatted output line from the packer
//   COMMA/NEWLINE separator bytes shared with the packer
//   rr_next()     round-robin pointer increment with wrap
package uart_ev_pkg;

  localparam int TS_W = 64;
  localparam int ID_W = 16;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] end_ts;
    logic [TS_W-1:0] delta;
  } ev_t;

  localparam int       LINE_BYTES = 56;
  localparam bit [7:0] COMMA      = 8'h2C;
  localparam bit [7:0] NEWLINE    = 8'h0A;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_ev_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant.
// Ports:
//   req  in  N    request vector
//   ptr  in  PW   highest-priority index for this cycle
//   gnt  out N    one-hot grant (zero when no request)
//   idx  out PW   index of the granted request
//   any  out 1    at least one request present
module rr_arbiter
  import uart_ev_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int unsigned c;

  // Scan ptr, ptr+1, ... mod N and take the first requester.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_ev_arbiter.sv
// uart_ev_arbiter: merges N_CH timestamper event streams onto the single
// ev_valid/ev_ready port of the UART event packer with work-conserving
// round-robin arbitration and a single registered output slot.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready [N_CH]   per-channel handshake (at most one ready)
//   in_id/in_start/in_end/in_delta  packed per-channel event fields
//   ev_valid/ev_ready          slot full / slot consumed by packer
//   ev_id/ev_start/ev_end/ev_delta  registered event fields
//   ev_ch                      source channel of the held event
//   ev_cnt [N_CH*32]           per-channel saturating accept counters,
//                              present only with UART_EV_ARB_STATS_EN
module uart_ev_arbiter
  import uart_ev_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TS_W = 64,
  parameter int ID_W = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      in_valid,
  output logic [N_CH-1:0]      in_ready,
  input  logic [N_CH*ID_W-1:0] in_id,
  input  logic [N_CH*TS_W-1:0] in_start,
  input  logic [N_CH*TS_W-1:0] in_end,
  input  logic [N_CH*TS_W-1:0] in_delta,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [ID_W-1:0]      ev_id,
  output logic [TS_W-1:0]      ev_start,
  output logic [TS_W-1:0]      ev_end,
  output logic [TS_W-1:0]      ev_delta,
  output logic [CH_W-1:0]      ev_ch
`ifdef UART_EV_ARB_STATS_EN
  ,
  output logic [N_CH*32-1:0]   ev_cnt
`endif
);

  logic [CH_W-1:0] rr_ptr;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gidx;
  logic            gany;
  logic            load;
  logic            accept;

  rr_arbiter #(.N(N_CH), .PW(CH_W)) u_rr (
    .req (in_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // Slot can take a new event when empty or being drained this cycle.
  assign load     = !ev_valid || ev_ready;
  assign in_ready = (load && !rst) ? gnt : '0;
  assign accept   = load && gany && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_start <= '0;
      ev_end   <= '0;
      ev_delta <= '0;
      ev_ch    <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      ev_valid <= 1'b1;
      ev_id    <= in_id[int'(gidx)*ID_W +: ID_W];
      ev_start <= in_start[int'(gidx)*TS_W +: TS_W];
      ev_end   <= in_end[int'(gidx)*TS_W +: TS_W];
      ev_delta <= in_delta[int'(gidx)*TS_W +: TS_W];
      ev_ch    <= gidx;
      rr_ptr   <= CH_W'(rr_next(int'(gidx), N_CH));
    end else if (ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

`ifdef UART_EV_ARB_STATS_EN
  logic [31:0] cnt_q [N_CH];

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (rst) begin
        cnt_q[c] <= '0;
      end else if (accept && int'(gidx) == c && cnt_q[c] != '1) begin
        cnt_q[c] <= cnt_q[c] + 32'd1;
      end
    end
  end

  always_comb begin
    ev_cnt = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      ev_cnt[c*32 +: 32] = cnt_q[c];
    end
  end
`endif

endmodule
